// File: rtl/qrcode_pkg.sv
// qrcode_pkg: shared register map, result-word layout, box slot type and reader FSM states
package qrcode_pkg;
  localparam logic [10:0] CTRL_ADDR   = 11'd0;
  localparam logic [10:0] THRESH_ADDR = 11'd1;
  localparam logic [10:0] RESULT_BASE = 11'd1024;
  localparam int VCNT_LSB = 20;
  localparam int HST_LSB  = 10;
  localparam int HED_LSB  = 0;
  localparam logic [31:0] TERMINATOR = 32'hFFFF_FFFF;
  typedef struct packed {
    logic [9:0] hst;
    logic [9:0] hed;
    logic [9:0] vst;
    logic [9:0] ved;
    logic [9:0] cx;
    logic       open;
  } box_t;
  typedef enum logic [3:0] {
    sIDLE, sPOLL, sPOLLW, sGAP, sREAD, sREADW, sPROC, sPUBLISH, sREFRESH
  } state_t;
  function automatic logic [9:0] absdiff(input logic [9:0] a, input logic [9:0] b);
    return a > b ? a - b : b - a;
  endfunction
endpackage

// File: rtl/qrcode_box_cluster.sv
// qrcode_box_cluster: merges per-line finder hits into three bounding-box slots, one entry per cycle
module qrcode_box_cluster
  import qrcode_pkg::*;
#(
  parameter int pXTOL = 4,
  parameter int pVGAP = 2
) (
  input  logic           iCLK,
  input  logic           iRESET_N,
  input  logic           iCLEAR,
  input  logic           iVALID,
  input  logic [29:0]    iENTRY,
  output box_t [2:0]     oSLOTS,
  output logic           oOVERFLOW
);
  box_t [2:0] slots_q, slots_d;
  logic       ovf_q, ovf_d;
  logic [9:0] vcnt, hs, he, cx;
  logic [10:0] sum;
  logic [2:0] hit;
  logic       placed;
  assign vcnt = iENTRY[VCNT_LSB +: 10];
  assign hs   = iENTRY[HST_LSB +: 10];
  assign he   = iENTRY[HED_LSB +: 10];
  assign sum  = {1'b0, hs} + {1'b0, he};
  assign cx   = sum[10:1];
  always_comb begin
    hit     = '0;
    placed  = 1'b0;
    slots_d = slots_q;
    ovf_d   = ovf_q;
    for (int k = 0; k < 3; k++)
      hit[k] = slots_q[k].open && absdiff(cx, slots_q[k].cx) <= 10'(pXTOL) &&
               vcnt >= slots_q[k].ved && (vcnt - slots_q[k].ved) <= 10'(pVGAP);
    if (iCLEAR) begin
      slots_d = '0;
      ovf_d   = 1'b0;
    end else if (iVALID && hs <= he) begin
      for (int k = 0; k < 3; k++)
        if (!placed && hit[k]) begin
          placed         = 1'b1;
          slots_d[k].ved = vcnt;
          slots_d[k].hst = hs < slots_q[k].hst ? hs : slots_q[k].hst;
          slots_d[k].hed = he > slots_q[k].hed ? he : slots_q[k].hed;
        end
      // no existing box accepted the hit: open the lowest free slot
      for (int k = 0; k < 3; k++)
        if (!placed && !slots_q[k].open) begin
          placed     = 1'b1;
          slots_d[k] = '{hst: hs, hed: he, vst: vcnt, ved: vcnt, cx: cx, open: 1'b1};
        end
      ovf_d = ovf_q | ~placed;
    end
  end
  always_ff @(posedge iCLK or negedge iRESET_N)
    if (!iRESET_N) begin
      slots_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      slots_q <= slots_d;
      ovf_q   <= ovf_d;
    end
  assign oSLOTS    = slots_q;
  assign oOVERFLOW = ovf_q;
endmodule

// File: rtl/qrcode_result_reader.sv
// qrcode_result_reader: bus master that polls the finder, clusters its result list into boxes and re-arms it
module qrcode_result_reader
  import qrcode_pkg::*;
#(
  parameter int pMAX_ENTRIES = 1023,
  parameter int pXTOL        = 4,
  parameter int pVGAP        = 2,
  parameter int pMIN_LINES   = 3,
  parameter int pPOLL_GAP    = 64
) (
  input  logic        iCLK,
  input  logic        iRESET_N,
  input  logic        iENABLE,
  output logic [10:0] oADDRESS,
  output logic        oREAD,
  output logic        oWRITE,
  output logic [31:0] oWRITE_DATA,
  input  logic [31:0] iREAD_DATA,
  output logic [2:0]  oBOX_VALID,
  output logic [29:0] oBOX_HST,
  output logic [29:0] oBOX_HED,
  output logic [29:0] oBOX_VST,
  output logic [29:0] oBOX_VED,
  output logic        oOVERFLOW,
  output logic        oFRAME_DONE,
  output logic        oBUSY
);
  state_t      state_q;
  logic [9:0]  idx_q;
  logic [15:0] gap_q;
  logic [29:0] word_q;
  logic [1:0]  outmode_q;
  logic [10:0] addr_q;
  logic        rd_q, wr_q, done_q, ovf_q;
  logic [31:0] wdata_q;
  logic [2:0]  valid_q;
  logic [29:0] hst_q, hed_q, vst_q, ved_q;
  box_t [2:0]  slots;
  logic        slot_ovf;
  qrcode_box_cluster #(.pXTOL(pXTOL), .pVGAP(pVGAP)) u_cluster (
    .iCLK      (iCLK),
    .iRESET_N  (iRESET_N),
    .iCLEAR    (state_q == sPOLLW && iREAD_DATA[0]),
    .iVALID    (state_q == sPROC),
    .iENTRY    (word_q),
    .oSLOTS    (slots),
    .oOVERFLOW (slot_ovf)
  );
  // strobes are raised on entry to sPOLL/sREAD so read data lands in the following wait state
  always_ff @(posedge iCLK or negedge iRESET_N)
    if (!iRESET_N) begin
      state_q   <= sIDLE;
      idx_q     <= '0;
      gap_q     <= '0;
      word_q    <= '0;
      outmode_q <= '0;
      addr_q    <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      valid_q   <= '0;
      hst_q     <= '0;
      hed_q     <= '0;
      vst_q     <= '0;
      ved_q     <= '0;
    end else begin
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        sIDLE: if (iENABLE) begin
          state_q <= sPOLL;
          rd_q    <= 1'b1;
          addr_q  <= CTRL_ADDR;
        end
        sPOLL: state_q <= sPOLLW;
        sPOLLW: begin
          outmode_q <= iREAD_DATA[2:1];
          if (iREAD_DATA[0]) begin
            idx_q   <= '0;
            state_q <= sREAD;
            rd_q    <= 1'b1;
            addr_q  <= RESULT_BASE;
          end else begin
            gap_q   <= '0;
            state_q <= sGAP;
          end
        end
        sGAP: if (gap_q == 16'(pPOLL_GAP - 1)) begin
          state_q <= sPOLL;
          rd_q    <= 1'b1;
          addr_q  <= CTRL_ADDR;
        end else gap_q <= gap_q + 16'd1;
        sREAD: state_q <= sREADW;
        sREADW: begin
          word_q  <= iREAD_DATA[29:0];
          state_q <= (iREAD_DATA == TERMINATOR || idx_q == 10'(pMAX_ENTRIES - 1)) ? sPUBLISH : sPROC;
        end
        sPROC: begin
          idx_q   <= idx_q + 10'd1;
          state_q <= sREAD;
          rd_q    <= 1'b1;
          addr_q  <= {1'b1, idx_q + 10'd1};
        end
        sPUBLISH: begin
          for (int k = 0; k < 3; k++) begin
            valid_q[k]         <= slots[k].open && (slots[k].ved - slots[k].vst) >= 10'(pMIN_LINES - 1);
            hst_q[10*k +: 10]  <= slots[k].hst;
            hed_q[10*k +: 10]  <= slots[k].hed;
            vst_q[10*k +: 10]  <= slots[k].vst;
            ved_q[10*k +: 10]  <= slots[k].ved;
          end
          ovf_q   <= slot_ovf;
          done_q  <= 1'b1;
          wr_q    <= 1'b1;
          addr_q  <= CTRL_ADDR;
          wdata_q <= {29'b0, outmode_q, 1'b1};
          state_q <= sREFRESH;
        end
        sREFRESH: state_q <= sIDLE;
        default:  state_q <= sIDLE;
      endcase
    end
  assign oADDRESS    = addr_q;
  assign oREAD       = rd_q;
  assign oWRITE      = wr_q;
  assign oWRITE_DATA = wdata_q;
  assign oBOX_VALID  = valid_q;
  assign oBOX_HST    = hst_q;
  assign oBOX_HED    = hed_q;
  assign oBOX_VST    = vst_q;
  assign oBOX_VED    = ved_q;
  assign oOVERFLOW   = ovf_q;
  assign oFRAME_DONE = done_q;
  assign oBUSY       = state_q != sIDLE;
endmodule

// File: tb/tb_qrcode_result_reader.sv
// tb_qrcode_result_reader: directed bench with a behavioural finder slave model
module tb_qrcode_result_reader;
  logic        iCLK = 1'b0;
  logic        iRESET_N = 1'b0;
  logic        iENABLE = 1'b0;
  logic [10:0] oADDRESS;
  logic        oREAD, oWRITE;
  logic [31:0] oWRITE_DATA;
  logic [31:0] iREAD_DATA = '0;
  logic [2:0]  oBOX_VALID;
  logic [29:0] oBOX_HST, oBOX_HED, oBOX_VST, oBOX_VED;
  logic        oOVERFLOW, oFRAME_DONE, oBUSY;
  int checks = 0;
  int errors = 0;
  qrcode_result_reader dut (
    .iCLK(iCLK), .iRESET_N(iRESET_N), .iENABLE(iENABLE),
    .oADDRESS(oADDRESS), .oREAD(oREAD), .oWRITE(oWRITE), .oWRITE_DATA(oWRITE_DATA),
    .iREAD_DATA(iREAD_DATA), .oBOX_VALID(oBOX_VALID),
    .oBOX_HST(oBOX_HST), .oBOX_HED(oBOX_HED), .oBOX_VST(oBOX_VST), .oBOX_VED(oBOX_VED),
    .oOVERFLOW(oOVERFLOW), .oFRAME_DONE(oFRAME_DONE), .oBUSY(oBUSY)
  );
  always #5 iCLK = ~iCLK;
  logic [31:0] res [0:1023];
  int arm_cnt = 0, hold = 0, poll_base = 0;
  int refresh_cnt = 0, polls = 0, cyc = 0, last_poll = 0, poll_gap = 0;
  int res_reads = 0, res0_reads = 0, last_res = 0, writes = 0, bus_viol = 0;
  logic [31:0] last_wdata = '0;
  logic [10:0] last_waddr = '0;
  logic [1:0]  outmode = 2'd2;
  // UPDATE reads high once armed and the requested number of polls has been answered with 0
  always @(posedge iCLK) begin
    cyc <= cyc + 1;
    if (oREAD && oWRITE) bus_viol <= bus_viol + 1;
    if (oREAD) begin
      if (oADDRESS[10]) begin
        iREAD_DATA <= res[oADDRESS[9:0]];
        res_reads  <= res_reads + 1;
        last_res   <= int'(oADDRESS[9:0]);
        if (oADDRESS == 11'h400) res0_reads <= res0_reads + 1;
      end else begin
        iREAD_DATA <= {29'b0, outmode, (arm_cnt > refresh_cnt) && (polls - poll_base >= hold)};
        polls      <= polls + 1;
        poll_gap   <= cyc - last_poll;
        last_poll  <= cyc;
      end
    end else iREAD_DATA <= 32'hDEAD_BEEF;
    if (oWRITE) begin
      writes     <= writes + 1;
      last_wdata <= oWRITE_DATA;
      last_waddr <= oADDRESS;
      if (oADDRESS == 11'h0) outmode <= oWRITE_DATA[2:1];
      if (oADDRESS == 11'h0 && oWRITE_DATA[0]) refresh_cnt <= refresh_cnt + 1;
    end
  end
  function automatic logic [31:0] ent(input int v, input int hs, input int he);
    return {2'b0, 10'(v), 10'(hs), 10'(he)};
  endfunction
  function automatic logic [9:0] f10(input logic [29:0] v, input int k);
    return v[10*k +: 10];
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask
  task automatic clear_res();
    for (int i = 0; i < 1024; i++) res[i] = 32'hFFFF_FFFF;
  endtask
  task automatic wait_done(input int bound);
    int n = 0;
    while (!oFRAME_DONE && n < bound) begin
      @(negedge iCLK);
      n++;
    end
    chk("frame_done", 32'(oFRAME_DONE), 32'd1);
  endtask
  task automatic run_frame(input int bound, input int h);
    hold = h;
    poll_base = polls;
    arm_cnt++;
    iENABLE = 1'b1;
    wait_done(bound);
    iENABLE = 1'b0;
    repeat (4) @(negedge iCLK);
  endtask
  task automatic chk_t1(input string p);
    chk({p, "_valid"}, 32'(oBOX_VALID), 32'b001);
    chk({p, "_hst0"}, 32'(f10(oBOX_HST, 0)), 32'd50);
    chk({p, "_hed0"}, 32'(f10(oBOX_HED, 0)), 32'd71);
    chk({p, "_vst0"}, 32'(f10(oBOX_VST, 0)), 32'd100);
    chk({p, "_ved0"}, 32'(f10(oBOX_VED, 0)), 32'd102);
    chk({p, "_ovf"}, 32'(oOVERFLOW), 32'd0);
  endtask
  task automatic load_t1();
    clear_res();
    res[0] = ent(100, 50, 70);
    res[1] = ent(101, 51, 71);
    res[2] = ent(102, 50, 70);
  endtask
  initial begin
    int s_res, s_res0, s_wr, n;
    #1;
    chk("rst_valid", 32'(oBOX_VALID), 0);
    chk("rst_boxes", 32'(oBOX_HST | oBOX_HED | oBOX_VST | oBOX_VED), 0);
    chk("rst_bus", {oADDRESS, oREAD, oWRITE}, 0);
    chk("rst_wdata", oWRITE_DATA, 0);
    chk("rst_flags", {oOVERFLOW, oFRAME_DONE, oBUSY}, 0);
    repeat (3) @(negedge iCLK);
    iRESET_N = 1'b1;
    @(negedge iCLK);
    chk("idle_busy", 32'(oBUSY), 0);
    // single finder pattern, UPDATE withheld for three polls
    load_t1();
    s_res = res_reads; s_res0 = res0_reads; s_wr = writes;
    run_frame(2000, 3);
    chk("t1_polls", polls - poll_base, 4);
    chk("t1_poll_gap", poll_gap, 66);
    chk("t1_res0_reads", res0_reads - s_res0, 1);
    chk("t1_res_reads", res_reads - s_res, 4);
    chk_t1("t1");
    chk("t1_writes", writes - s_wr, 1);
    chk("t1_waddr", 32'(last_waddr), 0);
    chk("t1_wdata", last_wdata, 32'h5);
    chk("t1_busy", 32'(oBUSY), 0);
    // three columns plus a fourth that finds no free slot
    clear_res();
    n = 0;
    for (int v = 10; v < 14; v++) begin
      res[n++] = ent(v, 50, 70);
      res[n++] = ent(v, 290, 310);
      if (v == 12) res[n++] = ent(v, 390, 410);
      res[n++] = ent(v, 490, 510);
    end
    run_frame(2000, 0);
    chk("t2_valid", 32'(oBOX_VALID), 32'b111);
    chk("t2_ovf", 32'(oOVERFLOW), 1);
    chk("t2_box0", {f10(oBOX_HST, 0), f10(oBOX_HED, 0), f10(oBOX_VED, 0)}, {10'd50, 10'd70, 10'd13});
    chk("t2_box1", {f10(oBOX_HST, 1), f10(oBOX_HED, 1), f10(oBOX_VST, 1)}, {10'd290, 10'd310, 10'd10});
    chk("t2_box2", {f10(oBOX_HST, 2), f10(oBOX_HED, 2), f10(oBOX_VED, 2)}, {10'd490, 10'd510, 10'd13});
    // vertical gap of 3 splits the column; a malformed entry in between is ignored
    clear_res();
    res[0] = ent(10, 100, 120);
    res[1] = ent(11, 200, 150);
    res[2] = ent(13, 100, 120);
    run_frame(2000, 0);
    chk("t3_valid", 32'(oBOX_VALID), 0);
    chk("t3_ovf", 32'(oOVERFLOW), 0);
    chk("t3_box0", {f10(oBOX_VST, 0), f10(oBOX_VED, 0)}, {10'd10, 10'd10});
    chk("t3_box1", {f10(oBOX_VST, 1), f10(oBOX_VED, 1), f10(oBOX_HST, 1)}, {10'd13, 10'd13, 10'd100});
    chk("t3_box2", 32'(f10(oBOX_HST, 2)), 0);
    // list without terminator stops after index 1022
    for (int i = 0; i < 1024; i++) res[i] = ent(5, 10, 20);
    s_res = res_reads;
    run_frame(6000, 0);
    chk("t4_res_reads", res_reads - s_res, 1023);
    chk("t4_last_idx", last_res, 1022);
    chk("t4_box0", {f10(oBOX_HST, 0), f10(oBOX_VST, 0), f10(oBOX_VED, 0)}, {10'd10, 10'd5, 10'd5});
    chk("t4_valid", 32'(oBOX_VALID), 0);
    // reset during sREADW, then re-read the same list
    load_t1();
    hold = 0;
    poll_base = polls;
    arm_cnt++;
    iENABLE = 1'b1;
    n = 0;
    while (!(oREAD && oADDRESS == 11'h401) && n < 500) begin
      @(negedge iCLK);
      n++;
    end
    chk("t5_reach_read1", 32'(oREAD && oADDRESS == 11'h401), 1);
    @(negedge iCLK);
    s_wr = writes;
    iRESET_N = 1'b0;
    #1;
    chk("t5_rst_boxes", 32'(oBOX_HST | oBOX_HED | oBOX_VST | oBOX_VED), 0);
    chk("t5_rst_flags", {oBOX_VALID, oOVERFLOW, oFRAME_DONE, oBUSY, oREAD, oWRITE}, 0);
    chk("t5_rst_addr", {oADDRESS, oWRITE_DATA[20:0]}, 0);
    repeat (3) @(negedge iCLK);
    chk("t5_no_refresh", writes - s_wr, 0);
    iRESET_N = 1'b1;
    wait_done(2000);
    iENABLE = 1'b0;
    repeat (4) @(negedge iCLK);
    chk_t1("t5");
    chk("t5_writes", writes - s_wr, 1);
    chk("t5_wdata", last_wdata, 32'h5);
    chk("bus_one_strobe", bus_viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
